cell_alu: RTL and testbench
===========================

# cell_alu

Parametrised, handshaked cell arithmetic unit that replaces the combinational per-opcode cell functions of the image processor. It accepts one cell (CELL_N×CELL_N pixels), a second cell or immediate, and an opcode. It returns one result pixel per transaction. Center-pixel ops finish in two cycles; AVG accumulates serially and then divides exactly. It sits between the line/cell buffer and the output frame buffer of the image processor core.

## Interface
- CH_W, 8: bits per color channel
- CH_N, 3: channels per pixel
- CELL_N, 3: cell edge length (odd, ≥3)
- SATURATE, 1: 1 = clamp arithmetic to [0, 2^CH_W−1]; 0 = modulo 2^CH_W
- Derived: PIX_W = CH_W·CH_N; N2 = CELL_N²; CENTER = (N2−1)/2; SUM_W = CH_W + clog2(N2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- in_opcode  in  4  opcodes_t
- in_cell_a  in  N2·PIX_W  cell A; pixel k at [k·PIX_W +: PIX_W]
- in_cell_b  in  N2·PIX_W  cell B (binary ops)
- in_imm  in  PIX_W  immediate; channel c uses [c·CH_W +: CH_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pixel  out  PIX_W  result pixel
- out_err  out  1  opcode was unsupported (valid with out_valid)

## Operation
- Transfer occurs when valid&ready are both high at a rising edge. On accept, capture the opcode, A, B, and imm into registers. Later input changes are ignored.
- FSM states: IDLE, EXEC, ACCUM, DIVIDE, DONE. in_ready = (state==IDLE).
  - IDLE→EXEC on accept of a non-AVG opcode; IDLE→ACCUM on accept of AVG.
  - EXEC→DONE after 1 cycle.
  - ACCUM runs N2 cycles, adding pixel k (k=0..N2−1, counter) of A into per-channel SUM_W accumulators cleared on accept, then goes to DIVIDE.
  - DIVIDE runs SUM_W cycles of a restoring divide by N2, all channels in parallel, then goes to DONE.
  - DONE→IDLE on out_ready. There is no IDLE bypass; the next accept is possible the cycle after the handshake.
- Per channel, a = A[CENTER], b = B[CENTER] or imm as the op requires:
  - ADD/ADDI: a+b
  - SUB/SUBI: a−b
  - MULT/MULTI: a·b (full product, then clamp or truncate to CH_W)
  - DIV2: a>>1
  - INV: ~a
  - AND/OR/NOR: bitwise with B
  - AVG: floor(Σ A[k].c / N2)
- Width rule: compute in CH_W+1 bits (2·CH_W for MULT). With SATURATE=1, overflow→max and underflow→0; with SATURATE=0, keep the low CH_W bits.
- Opcodes 12–15: out_pixel = A[CENTER], out_err=1, EXEC path.
- out_pixel and out_err are registered. They are stable from DONE entry until the handshake.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_pixel 0, out_err 0, accumulators and counters 0.
- Latency is measured from the accept edge (cycle 0) to the first out_valid cycle:
  - non-AVG: 2
  - AVG: N2+SUM_W+1 (22 with the defaults)
- Best-case throughput is one result per latency+1 cycles.
- Backpressure: DONE holds indefinitely with outputs frozen while out_ready=0.
- in_valid during non-IDLE states is not accepted; the source must hold it.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result is discarded.
- Accumulator width SUM_W never overflows: N2·(2^CH_W−1) < 2^SUM_W.

## Structure
- Shared CellProcessingPkg holds:
  - CH_W, CH_N, CELL_N defaults
  - opcodes_t (existing 12 encodings, ADD=0 … AVG=11)
  - pixel_t and cell_t union types parametrised from the package constants
  - the per-channel saturating add/sub/mult helper functions
- One sub-module, cell_div_unit: a sequential restoring divider for one SUM_W-bit dividend by the constant N2. It has start/done signals and is instantiated CH_N times.

## Test plan
- ADD, SATURATE=1: center channels A=(200,10,0), B=(100,5,0) → (255,15,0), out_valid at cycle 2. With SATURATE=0 → (44,15,0).
- SUBI with imm=(20,20,20), A center=(10,30,20) → SATURATE=1 gives (0,10,0); SATURATE=0 gives (246,10,0).
- AVG: pixel k has all channels = k (0..8) → (4,4,4) at cycle 22. All channels = 255 → (255,255,255). Channel sum 80 → 8.
- Backpressure: hold out_ready=0 for 10 cycles after DONE → out_pixel and out_valid stable, in_ready=0; release → in_ready=1 the next cycle.
- Reset pulse at cycle 5 of AVG → outputs take reset values immediately. A following ADD completes correctly, with no residue from the accumulators.
- Opcode 13 with A center=(1,2,3) → out_pixel=(1,2,3), out_err=1. A following ADD gives out_err=0.

Source files
------------

// File: rtl/CellProcessingPkg.sv
// Shared cell-processing constants, opcode encodings, pixel/cell views and
// per-channel saturating arithmetic helpers.
package CellProcessingPkg;
   localparam int CH_W   = 8;
   localparam int CH_N   = 3;
   localparam int CELL_N = 3;
   localparam int PIX_W  = CH_W * CH_N;
   localparam int N2     = CELL_N * CELL_N;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0, OP_ADDI  = 4'd1, OP_SUB  = 4'd2, OP_SUBI = 4'd3,
      OP_MULT = 4'd4, OP_MULTI = 4'd5, OP_DIV2 = 4'd6, OP_INV  = 4'd7,
      OP_AND  = 4'd8, OP_OR    = 4'd9, OP_NOR  = 4'd10, OP_AVG = 4'd11
   } opcodes_t;

   typedef union packed {
      logic [PIX_W-1:0]           flat;
      logic [CH_N-1:0][CH_W-1:0]  ch;
   } pixel_t;

   typedef union packed {
      logic [N2*PIX_W-1:0]  flat;
      pixel_t [N2-1:0]      pix;
   } cell_t;

   // Channels are passed zero-extended to 32 bits; w is the real channel width.
   function automatic logic [31:0] ch_max(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic logic [31:0] ch_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input bit sat);
      logic [31:0] s;
      s = a + b;
      if (sat && (s > ch_max(w))) return ch_max(w);
      return s & ch_max(w);
   endfunction

   function automatic logic [31:0] ch_sub(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input bit sat);
      if (a < b) return sat ? 32'd0 : ((a - b) & ch_max(w));
      return a - b;
   endfunction

   function automatic logic [31:0] ch_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input bit sat);
      logic [31:0] p;
      p = a * b;
      if (sat && (p > ch_max(w))) return ch_max(w);
      return p & ch_max(w);
   endfunction
endpackage

// File: rtl/cell_div_unit.sv
// Sequential restoring divider: W-bit dividend by a constant DIVISOR, one
// quotient bit per cycle. The first step happens on the start cycle itself.
module cell_div_unit #(
   parameter int W       = 12,
   parameter int DIVISOR = 9,
   parameter int QW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [W-1:0]  i_dividend,
   output logic          o_busy,
   output logic          o_done,
   output logic [QW-1:0] o_quot
);
   localparam int RW = $clog2(DIVISOR) + 1;
   localparam int CW = $clog2(W + 1);
   localparam logic [RW:0]   D_VAL = (RW + 1)'(DIVISOR);
   localparam logic [CW-1:0] C_LAST = CW'(W - 1);

   logic [RW-1:0] r_rem;
   logic [W-1:0]  r_quo;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   logic [RW-1:0] w_src_rem;
   logic [W-1:0]  w_src_quo;
   logic [RW:0]   w_trial;
   logic          w_ge;
   logic [RW-1:0] w_rem_n;
   logic [W-1:0]  w_quo_n;

   always_comb begin
      w_src_rem = i_start ? '0 : r_rem;
      w_src_quo = i_start ? i_dividend : r_quo;
      w_trial   = {w_src_rem, w_src_quo[W-1]};
      w_ge      = (w_trial >= D_VAL);
      w_rem_n   = w_ge ? RW'(w_trial - D_VAL) : RW'(w_trial);
      w_quo_n   = {w_src_quo[W-2:0], w_ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_rem  <= w_rem_n;
         r_quo  <= w_quo_n;
         r_cnt  <= CW'(1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem <= w_rem_n;
         r_quo <= w_quo_n;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == C_LAST) r_busy <= 1'b0;
      end
   end

   // o_done flags the cycle whose edge completes the last step; o_quot is the
   // quotient that edge produces, so a consumer can register it directly.
   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == C_LAST);
   assign o_quot = w_quo_n[QW-1:0];
endmodule

// File: rtl/cell_alu.sv
// Handshaked cell arithmetic unit: center-pixel ops in two cycles, AVG by
// serial accumulation followed by an exact restoring divide.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_EXEC   | evaluate center-pixel op
// S_ACCUM  | add pixel k of A into the channel sums
// S_DIVIDE | divide channel sums by N2
// S_DONE   | result held until out_ready
module cell_alu #(
   parameter int CH_W     = CellProcessingPkg::CH_W,
   parameter int CH_N     = CellProcessingPkg::CH_N,
   parameter int CELL_N   = CellProcessingPkg::CELL_N,
   parameter bit SATURATE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    in_opcode,
   input  logic [CELL_N*CELL_N*CH_W*CH_N-1:0] in_cell_a,
   input  logic [CELL_N*CELL_N*CH_W*CH_N-1:0] in_cell_b,
   input  logic [CH_W*CH_N-1:0]          in_imm,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CH_W*CH_N-1:0]          out_pixel,
   output logic                          out_err
);
   import CellProcessingPkg::*;

   localparam int PIX_W  = CH_W * CH_N;
   localparam int N2     = CELL_N * CELL_N;
   localparam int CENTER = (N2 - 1) / 2;
   localparam int SUM_W  = CH_W + $clog2(N2);
   localparam int KW     = $clog2(N2);
   localparam logic [KW-1:0] K_LAST = KW'(N2 - 1);

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ACCUM, S_DIVIDE, S_DONE} state_t;

   state_t                     r_state;
   logic [3:0]                 r_op;
   logic [N2*PIX_W-1:0]        r_a;
   logic [PIX_W-1:0]           r_b;
   logic [PIX_W-1:0]           r_imm;
   logic [CH_N-1:0][SUM_W-1:0] r_acc;
   logic [KW-1:0]              r_k;
   logic                       r_in_ready;
   logic                       r_out_valid;
   logic                       r_err;
   logic [PIX_W-1:0]           r_out;

   logic                       w_accept;
   logic [CH_N-1:0][CH_W-1:0]  w_ca, w_cb, w_ci, w_res, w_quot;
   logic [CH_N-1:0]            w_div_busy, w_div_done;
   logic                       w_div_start;

   assign w_accept = in_valid && r_in_ready;
   assign w_ca     = r_a[CENTER*PIX_W +: PIX_W];
   assign w_cb     = r_b;
   assign w_ci     = r_imm;

   always_comb begin
      w_res = w_ca;
      for (int c = 0; c < CH_N; c++) begin
         case (r_op)
            OP_ADD:   w_res[c] = CH_W'(ch_add(32'(w_ca[c]), 32'(w_cb[c]), CH_W, SATURATE));
            OP_ADDI:  w_res[c] = CH_W'(ch_add(32'(w_ca[c]), 32'(w_ci[c]), CH_W, SATURATE));
            OP_SUB:   w_res[c] = CH_W'(ch_sub(32'(w_ca[c]), 32'(w_cb[c]), CH_W, SATURATE));
            OP_SUBI:  w_res[c] = CH_W'(ch_sub(32'(w_ca[c]), 32'(w_ci[c]), CH_W, SATURATE));
            OP_MULT:  w_res[c] = CH_W'(ch_mul(32'(w_ca[c]), 32'(w_cb[c]), CH_W, SATURATE));
            OP_MULTI: w_res[c] = CH_W'(ch_mul(32'(w_ca[c]), 32'(w_ci[c]), CH_W, SATURATE));
            OP_DIV2:  w_res[c] = w_ca[c] >> 1;
            OP_INV:   w_res[c] = ~w_ca[c];
            OP_AND:   w_res[c] = w_ca[c] & w_cb[c];
            OP_OR:    w_res[c] = w_ca[c] | w_cb[c];
            OP_NOR:   w_res[c] = ~(w_ca[c] | w_cb[c]);
            default:  w_res[c] = w_ca[c];
         endcase
      end
   end

   assign w_div_start = (r_state == S_DIVIDE) && !(|w_div_busy);

   for (genvar g = 0; g < CH_N; g++) begin : g_div
      cell_div_unit #(.W(SUM_W), .DIVISOR(N2), .QW(CH_W)) u_div (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_start   (w_div_start),
         .i_dividend(r_acc[g]),
         .o_busy    (w_div_busy[g]),
         .o_done    (w_div_done[g]),
         .o_quot    (w_quot[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_imm       <= '0;
         r_acc       <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_out       <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op       <= in_opcode;
               r_a        <= in_cell_a;
               r_b        <= in_cell_b[CENTER*PIX_W +: PIX_W];
               r_imm      <= in_imm;
               r_acc      <= '0;
               r_k        <= '0;
               r_in_ready <= 1'b0;
               r_state    <= (in_opcode == OP_AVG) ? S_ACCUM : S_EXEC;
            end
            S_EXEC: begin
               r_out       <= w_res;
               r_err       <= (r_op >= 4'd12);
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            // A is shifted down one pixel per cycle so pixel k is always at the bottom.
            S_ACCUM: begin
               for (int c = 0; c < CH_N; c++)
                  r_acc[c] <= r_acc[c] + SUM_W'(r_a[c*CH_W +: CH_W]);
               r_a <= r_a >> PIX_W;
               r_k <= r_k + 1'b1;
               if (r_k == K_LAST) begin
                  r_k     <= '0;
                  r_state <= S_DIVIDE;
               end
            end
            S_DIVIDE: if (&w_div_done) begin
               r_out       <= w_quot;
               r_err       <= 1'b0;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_pixel = r_out;
   assign out_err   = r_err;
endmodule

// File: tb/tb_cell_alu.sv
// Bench for cell_alu: saturating and modulo instances driven in lockstep,
// checked against fixed vectors and an arithmetic reference model.
module tb_cell_alu;
   localparam int PW = 24;
   localparam int CW = 9 * PW;
   typedef logic [PW-1:0] pix_t;
   typedef logic [CW-1:0] cell_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic [3:0]  in_opcode;
   cell_t       in_cell_a, in_cell_b;
   pix_t        in_imm;
   logic        rdy_s, vld_s, err_s, rdy_m, vld_m, err_m;
   pix_t        pix_s, pix_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cell_alu #(.SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
      .in_opcode(in_opcode), .in_cell_a(in_cell_a), .in_cell_b(in_cell_b),
      .in_imm(in_imm), .out_valid(vld_s), .out_ready(out_ready),
      .out_pixel(pix_s), .out_err(err_s));

   cell_alu #(.SATURATE(1'b0)) u_mod (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
      .in_opcode(in_opcode), .in_cell_a(in_cell_a), .in_cell_b(in_cell_b),
      .in_imm(in_imm), .out_valid(vld_m), .out_ready(out_ready),
      .out_pixel(pix_m), .out_err(err_m));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic pix_t mk(input int c0, input int c1, input int c2);
      return {c2[7:0], c1[7:0], c0[7:0]};
   endfunction

   function automatic cell_t mkcell(input pix_t center);
      cell_t c;
      for (int k = 0; k < 9; k++) c[k*PW +: PW] = PW'($urandom);
      c[4*PW +: PW] = center;
      return c;
   endfunction

   // Reference: {err, pixel} from the opcode rules using plain integers.
   function automatic logic [PW:0] model(input logic [3:0] op, input cell_t a, input cell_t b,
                                         input pix_t imm, input bit sat);
      pix_t p;
      logic e;
      e = 1'b0;
      for (int c = 0; c < 3; c++) begin
         int x, y, r, s;
         x = int'(a[4*PW + c*8 +: 8]);
         y = (op == 4'd1 || op == 4'd3 || op == 4'd5) ? int'(imm[c*8 +: 8]) : int'(b[4*PW + c*8 +: 8]);
         case (op)
            4'd0, 4'd1: r = x + y;
            4'd2, 4'd3: r = x - y;
            4'd4, 4'd5: r = x * y;
            4'd6:  r = x / 2;
            4'd7:  r = 255 - x;
            4'd8:  r = x & y;
            4'd9:  r = x | y;
            4'd10: r = 255 - (x | y);
            4'd11: begin
               s = 0;
               for (int k = 0; k < 9; k++) s += int'(a[k*PW + c*8 +: 8]);
               r = s / 9;
            end
            default: begin r = x; e = 1'b1; end
         endcase
         if (op <= 4'd5) begin
            if (sat) r = (r > 255) ? 255 : ((r < 0) ? 0 : r);
            else     r = ((r % 256) + 256) % 256;
         end
         p[c*8 +: 8] = r[7:0];
      end
      return {e, p};
   endfunction

   task automatic send(input logic [3:0] op, input cell_t a, input cell_t b, input pix_t imm);
      int n;
      n = 0;
      @(negedge clk);
      while (!rdy_s && n < 100) begin @(negedge clk); n++; end
      if (!rdy_s) chk("send_timeout", 32'd0, 32'd1);
      in_valid  = 1'b1;
      in_opcode = op;
      in_cell_a = a;
      in_cell_b = b;
      in_imm    = imm;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_cell_a = ~a;
      in_cell_b = ~b;
      in_imm    = ~imm;
      in_opcode = ~op;
   endtask

   task automatic collect(input int hold, output pix_t ps, output pix_t pm,
                          output logic es, output logic em, output int lat);
      int n;
      n = 1;
      lat = -1;
      out_ready = 1'b0;
      ps = '0; pm = '0; es = 1'b0; em = 1'b0;
      while (n < 100) begin
         @(negedge clk);
         if (vld_s) begin lat = n; break; end
         n++;
      end
      if (lat < 0) begin
         chk("result_timeout", 32'd0, 32'd1);
         return;
      end
      chk("valid_mod_sync", 32'(vld_m), 32'd1);
      ps = pix_s; pm = pix_m; es = err_s; em = err_m;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_pixel", pix_s, ps);
         chk("hold_valid", 32'(vld_s), 32'd1);
         chk("hold_in_ready", 32'(rdy_s), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_hs_in_ready", 32'(rdy_s), 32'd1);
      chk("post_hs_valid", 32'(vld_s), 32'd0);
   endtask

   typedef struct {
      logic [3:0] op;
      pix_t a, b, imm, exp_s, exp_m;
      logic err;
   } vec_t;

   vec_t vecs[14];

   initial begin
      pix_t ps, pm;
      logic es, em;
      int lat;
      cell_t ca, cb;
      logic [PW:0] ref_s, ref_m;

      vecs[0]  = '{4'd0,  mk(200,10,0), mk(100,5,0), mk(0,0,0),    mk(255,15,0), mk(44,15,0), 1'b0};
      vecs[1]  = '{4'd3,  mk(10,30,20), mk(0,0,0),   mk(20,20,20), mk(0,10,0),   mk(246,10,0), 1'b0};
      vecs[2]  = '{4'd13, mk(1,2,3),    mk(9,9,9),   mk(7,7,7),    mk(1,2,3),    mk(1,2,3),   1'b1};
      vecs[3]  = '{4'd0,  mk(200,10,0), mk(100,5,0), mk(0,0,0),    mk(255,15,0), mk(44,15,0), 1'b0};
      vecs[4]  = '{4'd4,  mk(16,3,0),   mk(16,5,7),  mk(0,0,0),    mk(255,15,0), mk(0,15,0),  1'b0};
      vecs[5]  = '{4'd5,  mk(100,200,1),mk(0,0,0),   mk(2,2,2),    mk(200,255,2),mk(200,144,2),1'b0};
      vecs[6]  = '{4'd6,  mk(255,7,0),  mk(0,0,0),   mk(0,0,0),    mk(127,3,0),  mk(127,3,0), 1'b0};
      vecs[7]  = '{4'd7,  mk(0,255,15), mk(0,0,0),   mk(0,0,0),    mk(255,0,240),mk(255,0,240),1'b0};
      vecs[8]  = '{4'd8,  mk(240,170,255), mk(60,85,15), mk(0,0,0), mk(48,0,15),  mk(48,0,15), 1'b0};
      vecs[9]  = '{4'd9,  mk(240,170,255), mk(60,85,15), mk(0,0,0), mk(252,255,255), mk(252,255,255), 1'b0};
      vecs[10] = '{4'd10, mk(240,170,255), mk(60,85,15), mk(0,0,0), mk(3,0,0),    mk(3,0,0),   1'b0};
      vecs[11] = '{4'd2,  mk(5,0,255),  mk(10,0,1),  mk(0,0,0),    mk(0,0,254),  mk(251,0,254), 1'b0};
      vecs[12] = '{4'd1,  mk(255,254,0),mk(0,0,0),   mk(1,1,1),    mk(255,255,1),mk(0,255,1), 1'b0};
      vecs[13] = '{4'd15, mk(9,8,7),    mk(1,1,1),   mk(1,1,1),    mk(9,8,7),    mk(9,8,7),   1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = '0; in_cell_a = '0; in_cell_b = '0; in_imm = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(rdy_s), 32'd1);
      chk("rst_out_valid", 32'(vld_s), 32'd0);
      chk("rst_out_pixel", pix_s, 32'd0);
      chk("rst_out_err", 32'(err_s), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         send(vecs[i].op, mkcell(vecs[i].a), mkcell(vecs[i].b), vecs[i].imm);
         collect(0, ps, pm, es, em, lat);
         chk($sformatf("vec%0d_latency", i), lat, 32'd2);
         chk($sformatf("vec%0d_pixel_sat", i), ps, vecs[i].exp_s);
         chk($sformatf("vec%0d_pixel_mod", i), pm, vecs[i].exp_m);
         chk($sformatf("vec%0d_err_sat", i), 32'(es), 32'(vecs[i].err));
         chk($sformatf("vec%0d_err_mod", i), 32'(em), 32'(vecs[i].err));
      end

      for (int k = 0; k < 9; k++) ca[k*PW +: PW] = mk(k, k, k);
      send(4'd11, ca, mkcell('0), '0);
      collect(0, ps, pm, es, em, lat);
      chk("avg_ramp_latency", lat, 32'd22);
      chk("avg_ramp_sat", ps, mk(4,4,4));
      chk("avg_ramp_mod", pm, mk(4,4,4));
      chk("avg_ramp_err", 32'(es), 32'd0);

      for (int k = 0; k < 9; k++) ca[k*PW +: PW] = mk(255, 255, 255);
      send(4'd11, ca, mkcell('0), '0);
      collect(0, ps, pm, es, em, lat);
      chk("avg_max_sat", ps, mk(255,255,255));
      chk("avg_max_mod", pm, mk(255,255,255));

      for (int k = 0; k < 9; k++) ca[k*PW +: PW] = mk((k < 8) ? 9 : 8, 0, (k == 0) ? 17 : 0);
      send(4'd11, ca, mkcell('0), '0);
      collect(0, ps, pm, es, em, lat);
      chk("avg_sum80_sat", ps, mk(8,0,1));

      send(4'd0, mkcell(mk(200,10,0)), mkcell(mk(100,5,0)), '0);
      collect(10, ps, pm, es, em, lat);
      chk("bp_pixel_sat", ps, mk(255,15,0));
      chk("bp_pixel_mod", pm, mk(44,15,0));

      for (int k = 0; k < 9; k++) ca[k*PW +: PW] = mk(255, 255, 255);
      send(4'd11, ca, mkcell('0), '0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(rdy_s), 32'd1);
      chk("midrst_out_valid", 32'(vld_s), 32'd0);
      chk("midrst_pixel_sat", pix_s, 32'd0);
      chk("midrst_pixel_mod", pix_m, 32'd0);
      chk("midrst_err", 32'(err_s), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'd0, mkcell(mk(20,30,40)), mkcell(mk(1,2,3)), '0);
      collect(0, ps, pm, es, em, lat);
      chk("postrst_latency", lat, 32'd2);
      chk("postrst_pixel", ps, mk(21,32,43));
      chk("postrst_err", 32'(es), 32'd0);

      for (int k = 0; k < 9; k++) ca[k*PW +: PW] = mk(k, 2*k, 3*k);
      send(4'd11, ca, mkcell('0), '0);
      collect(0, ps, pm, es, em, lat);
      chk("postrst_avg", ps, mk(4,8,12));

      for (int t = 0; t < 40; t++) begin
         logic [3:0] op;
         pix_t imm;
         op = 4'($urandom_range(0, 15));
         ca = mkcell(PW'($urandom));
         cb = mkcell(PW'($urandom));
         imm = PW'($urandom);
         ref_s = model(op, ca, cb, imm, 1'b1);
         ref_m = model(op, ca, cb, imm, 1'b0);
         send(op, ca, cb, imm);
         collect($urandom_range(0, 3), ps, pm, es, em, lat);
         chk($sformatf("rnd%0d_op%0d_latency", t, op), lat, (op == 4'd11) ? 32'd22 : 32'd2);
         chk($sformatf("rnd%0d_op%0d_sat", t, op), ps, 32'(ref_s[PW-1:0]));
         chk($sformatf("rnd%0d_op%0d_mod", t, op), pm, 32'(ref_m[PW-1:0]));
         chk($sformatf("rnd%0d_op%0d_err", t, op), 32'(es), 32'(ref_s[PW]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
